// File: rtl/operand_ext.sv
// Operand width extender (sign/zero extension or magnitude) behind a
// 2-entry valid/ready buffer. Results carry the original sign and a magnitude overflow flag.
module operand_ext #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_signed,
  input  logic             in_abs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg,
  output logic             out_ovf
);

  generate
    if ((OUT_W < IN_W) || (IN_W < 2)) begin : g_param_check
      $error("operand_ext: requires IN_W >= 2 and OUT_W >= IN_W");
    end
  endgenerate

  localparam logic [IN_W-1:0] MOST_NEG = IN_W'(1) << (IN_W - 1);

  // Result computation on the incoming operand
  logic [OUT_W-1:0] ext_w;
  logic [OUT_W-1:0] res_data_w;
  logic             res_neg_w;
  logic             res_ovf_w;

  always_comb begin
    ext_w = OUT_W'(in_data);
    if (in_signed) begin
      ext_w = OUT_W'($signed(in_data));
    end
    res_neg_w  = in_signed & in_data[IN_W-1];
    res_data_w = ext_w;
    if (in_abs && res_neg_w) begin
      res_data_w = ~ext_w + OUT_W'(1);
    end
    // Only the most-negative operand with no headroom bit cannot be negated;
    // its two's-complement negation wraps back to itself.
    res_ovf_w = in_abs & res_neg_w & (OUT_W == IN_W) & (in_data == MOST_NEG);
  end

  // Two-entry buffer state
  logic [OUT_W-1:0] data_q [2];
  logic [OUT_W-1:0] data_d [2];
  logic [1:0]       neg_q;
  logic [1:0]       neg_d;
  logic [1:0]       ovf_q;
  logic [1:0]       ovf_d;
  logic             wr_ptr_q;
  logic             wr_ptr_d;
  logic             rd_ptr_q;
  logic             rd_ptr_d;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;

  logic push;
  logic pop;

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign out_neg   = neg_q[rd_ptr_q];
  assign out_ovf   = ovf_q[rd_ptr_q];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    data_d   = data_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      data_d[wr_ptr_q] = res_data_w;
      neg_d[wr_ptr_q]  = res_neg_w;
      ovf_d[wr_ptr_q]  = res_ovf_w;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
      end
      neg_q    <= '0;
      ovf_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      data_q   <= data_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
